// File: rtl/busca_instrucao.sv
// Instruction fetch stage: drives the instruction-memory request, tracks PC and taken branches,
// and loads the IF/ID register. A word that arrives during a stall is parked in a buffer.
module busca_instrucao #(
  parameter logic [31:0] PC_INICIAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        desvio,
  input  logic [31:0] endereco_desvio,
  output logic        mem_req,
  output logic [31:0] mem_endereco,
  input  logic        mem_pronto,
  input  logic [31:0] mem_dado,
  output logic [31:0] pc_4,
  output logic [31:0] instrucao,
  output logic [15:0] imediato,
  output logic        valido
);

  typedef enum logic {BUSCA = 1'b0, PENDENTE = 1'b1} estado_t;

  estado_t     estado;
  logic [31:0] pc;
  logic [31:0] buf_pc_4;
  logic [31:0] buf_instrucao;
  logic        desvio_pend;
  logic [31:0] alvo_pend;

  logic        desvio_ativo;
  logic [31:0] alvo;
  logic [31:0] pc_mais_4;

  // A branch seen this cycle takes priority over an older pending one.
  assign desvio_ativo = desvio || desvio_pend;
  assign alvo         = desvio ? {endereco_desvio[31:2], 2'b00} : alvo_pend;
  assign pc_mais_4    = pc + 32'd4;

  assign mem_req      = (estado == BUSCA) && !reset;
  assign mem_endereco = pc;
  assign imediato     = instrucao[15:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      estado        <= BUSCA;
      pc            <= {PC_INICIAL[31:2], 2'b00};
      buf_pc_4      <= 32'h0;
      buf_instrucao <= 32'h0;
      desvio_pend   <= 1'b0;
      alvo_pend     <= 32'h0;
      pc_4          <= 32'h0;
      instrucao     <= 32'h0;
      valido        <= 1'b0;
    end else begin
      case (estado)
        BUSCA: begin
          if (mem_pronto) begin
            if (desvio_ativo) begin
              // Returned word belongs to the wrong path: discard and redirect.
              pc          <= alvo;
              desvio_pend <= 1'b0;
              if (!stall) begin
                valido    <= 1'b0;
                instrucao <= 32'h0;
              end
            end else if (stall) begin
              buf_pc_4      <= pc_mais_4;
              buf_instrucao <= mem_dado;
              estado        <= PENDENTE;
            end else begin
              pc_4      <= pc_mais_4;
              instrucao <= mem_dado;
              valido    <= 1'b1;
              pc        <= pc_mais_4;
            end
          end else begin
            if (desvio) begin
              desvio_pend <= 1'b1;
              alvo_pend   <= alvo;
            end
            if (!stall) begin
              valido    <= 1'b0;
              instrucao <= 32'h0;
            end
          end
        end
        PENDENTE: begin
          if (desvio) begin
            pc          <= alvo;
            desvio_pend <= 1'b0;
            estado      <= BUSCA;
            if (!stall) begin
              valido    <= 1'b0;
              instrucao <= 32'h0;
            end
          end else if (!stall) begin
            pc_4      <= buf_pc_4;
            instrucao <= buf_instrucao;
            valido    <= 1'b1;
            pc        <= pc_mais_4;
            estado    <= BUSCA;
          end
        end
        default: estado <= BUSCA;
      endcase
      // Flush wins over stall and over any load above.
      if (flush) begin
        valido    <= 1'b0;
        instrucao <= 32'h0;
      end
    end
  end

endmodule
